glb_addr_xlat: RTL

- Programmable, arbitrated successor to the combinational GLB address decoder.
- Holds a run-time GLB bank allocation register with per-region base offsets precomputed at configuration time.
- Arbitrates round-robin among NUM_CH requesters and translates each logical (region, address) pair into a physical bank select and in-bank address.
- Drives one registered, back-pressured output toward the GLB bank mux, and flags out-of-region accesses instead of silently aliasing into a neighbouring region.

---
 rtl/glb_addr_xlat.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/glb_addr_xlat.sv
// Round-robin arbitrated GLB address translator. It maps a per-channel (region, address) pair onto a
// physical bank and in-bank offset, using a run-time bank allocation. Out-of-region accesses are flagged.
module glb_addr_xlat #(
  parameter  int BANK_NUM   = 27,
  parameter  int BANK_DEPTH = 512,
  parameter  int NUM_REGION = 3,
  parameter  int NUM_CH     = 4,
  localparam int SEL_W      = $clog2(BANK_NUM),
  localparam int OFF_W      = $clog2(BANK_DEPTH),
  localparam int ADDR_W     = $clog2(BANK_NUM * BANK_DEPTH),
  localparam int TYPE_W     = $clog2(NUM_REGION + 1),
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_cfg_valid,
  input  logic [NUM_REGION*SEL_W-1:0]  i_cfg_alloc,
  output logic                         o_cfg_ready,
  output logic                         o_cfg_err,
  input  logic [NUM_CH-1:0]            i_req_valid,
  input  logic [NUM_CH*TYPE_W-1:0]     i_req_type,
  input  logic [NUM_CH*ADDR_W-1:0]     i_req_addr,
  output logic [NUM_CH-1:0]            o_req_ready,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [CH_W-1:0]              o_ch,
  output logic [SEL_W-1:0]             o_bank_sel,
  output logic [OFF_W-1:0]             o_bank_addr,
  output logic                         o_err,
  output logic [7:0]                   o_err_cnt
);

  localparam int SUM_W = SEL_W + $clog2(NUM_REGION + 1);

  logic [SEL_W-1:0]  count_q [1:NUM_REGION];
  logic [SEL_W-1:0]  count_d [1:NUM_REGION];
  logic [SEL_W-1:0]  base_q  [1:NUM_REGION];
  logic [SEL_W-1:0]  base_d  [1:NUM_REGION];
  logic              valid_q, valid_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic              err_q, err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              cfg_err_q, cfg_err_d;

  logic              cfg_ready, cfg_accept, cfg_ok;
  logic [SUM_W-1:0]  alloc_sum, run_base;
  logic [SEL_W-1:0]  field;
  logic              free, found, grant;
  logic [CH_W-1:0]   gnt_ch, cand;
  logic [TYPE_W-1:0] req_type;
  logic [ADDR_W-1:0] req_addr, req_idx;
  logic [SEL_W-1:0]  reg_count, reg_base;
  logic              type_ok, xlat_err;

  function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= NUM_CH) s = s - NUM_CH;
    return CH_W'(s);
  endfunction

  assign cfg_ready  = !valid_q && !i_rst;
  assign cfg_accept = i_cfg_valid && cfg_ready;

  // Region 1 sits in the MSB field; bases are prefix sums so translation needs only one add.
  always_comb begin
    alloc_sum = '0;
    run_base  = '0;
    field     = '0;
    count_d   = count_q;
    base_d    = base_q;
    for (int r = 1; r <= NUM_REGION; r++) begin
      alloc_sum = alloc_sum + SUM_W'(i_cfg_alloc[(NUM_REGION-r)*SEL_W +: SEL_W]);
    end
    cfg_ok = (alloc_sum <= SUM_W'(BANK_NUM));
    if (cfg_accept && cfg_ok) begin
      for (int r = 1; r <= NUM_REGION; r++) begin
        field      = i_cfg_alloc[(NUM_REGION-r)*SEL_W +: SEL_W];
        count_d[r] = field;
        base_d[r]  = SEL_W'(run_base);
        run_base   = run_base + SUM_W'(field);
      end
    end
  end

  // Scanning offsets downward leaves the nearest valid channel at or after the pointer.
  always_comb begin
    found  = 1'b0;
    gnt_ch = '0;
    cand   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand = wrap_add(ptr_q, i);
      if (i_req_valid[cand]) begin
        found  = 1'b1;
        gnt_ch = cand;
      end
    end
  end

  assign free  = !valid_q || i_ready;
  assign grant = free && found && !cfg_accept && !i_rst;

  always_comb begin
    req_type  = i_req_type[gnt_ch*TYPE_W +: TYPE_W];
    req_addr  = i_req_addr[gnt_ch*ADDR_W +: ADDR_W];
    req_idx   = req_addr >> OFF_W;
    reg_count = '0;
    reg_base  = '0;
    for (int r = 1; r <= NUM_REGION; r++) begin
      if (int'(req_type) == r) begin
        reg_count = count_q[r];
        reg_base  = base_q[r];
      end
    end
    type_ok  = (req_type != '0) && (int'(req_type) <= NUM_REGION);
    xlat_err = !type_ok || (req_idx >= ADDR_W'(reg_count));
  end

  always_comb begin
    valid_d   = valid_q;
    ch_d      = ch_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    off_d     = off_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    cfg_err_d = cfg_accept && !cfg_ok;
    if (grant) begin
      valid_d = 1'b1;
      ch_d    = gnt_ch;
      ptr_d   = wrap_add(gnt_ch, 1);
      err_d   = xlat_err;
      if (xlat_err) begin
        sel_d = '0;
        off_d = '0;
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end else begin
        sel_d = SEL_W'(ADDR_W'(reg_base) + req_idx);
        off_d = req_addr[OFF_W-1:0];
      end
    end else if (i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int r = 1; r <= NUM_REGION; r++) begin
        count_q[r] <= '0;
        base_q[r]  <= '0;
      end
      valid_q   <= 1'b0;
      ch_q      <= '0;
      ptr_q     <= '0;
      sel_q     <= '0;
      off_q     <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      base_q    <= base_d;
      valid_q   <= valid_d;
      ch_q      <= ch_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      off_q     <= off_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign o_cfg_ready = cfg_ready;
  assign o_cfg_err   = cfg_err_q;
  assign o_req_ready = grant ? (NUM_CH'(1) << gnt_ch) : '0;
  assign o_valid     = valid_q;
  assign o_ch        = ch_q;
  assign o_bank_sel  = sel_q;
  assign o_bank_addr = off_q;
  assign o_err       = err_q;
  assign o_err_cnt   = err_cnt_q;

endmodule
